hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised hazard unit for the 5-stage pipeline. It detects classic load-use hazards.
//  It also tracks variable-latency writebacks (loads with cache misses, mul/div) in a
//  per-register busy scoreboard, so the IF/ID stage stalls until the operand's writeback.
//  It also limits the number of outstanding long ops, flushes IF/ID on taken branches,
//  and runs a sticky watchdog that flags a stall lasting too long.
//  It sits between the IF/ID and ID/EX registers and drives PC/IF write enables and ID bubble insertion.
// PARAMETERS
//  REG_NUM_BITWIDTH  5   register index width; 2**REG_NUM_BITWIDTH architectural regs, x0 never busy
//  MAX_OUTSTANDING   4   max in-flight long-latency ops (1..2**REG_NUM_BITWIDTH-1)
//  WB_BYPASS         1   1: operand completing in WB this cycle is forwarded, not a hazard
//  WATCHDOG_CYCLES   255 consecutive stall cycles before hazard_error sets (>=1)
// PORTS
//  clk          in  1  clock, rising edge
//  rst_n        in  1  asynchronous active-low reset
//  id_valid     in  1  ID/EX holds a valid instruction advancing to EX this cycle
//  id_memRead   in  1  that instruction is a load
//  id_longOp    in  1  that instruction completes with variable latency (writes id_Rd via wb_*)
//  id_Rd        in  R  its destination register
//  if_Rs1       in  R  IF/ID source register 1
//  if_Rs2       in  R  IF/ID source register 2
//  if_longOp    in  1  IF/ID instruction is itself a long op
//  wb_valid     in  1  a long op writes back this cycle
//  wb_Rd        in  R  its destination register
//  ex_branchTaken in 1 taken branch/jump resolved in EX
//  PCWrite      out 1  PC update enable (0 = hold)
//  if_write     out 1  IF/ID register write enable (0 = hold)
//  id_doNOP     out 1  load bubble into ID/EX
//  if_flush     out 1  clear IF/ID to NOP
//  outstanding  out $clog2(MAX_OUTSTANDING+1)  in-flight long-op count
//  hazard_error out 1  sticky: watchdog expired, or issue at full, or completion at zero
// BEHAVIOUR
//  Reset (async, rst_n=0): busy[*]=0, outstanding=0, stall counter=0, hazard_error=0.
//   With idle inputs the outputs are PCWrite=1, if_write=1, id_doNOP=0, if_flush=0.
//  Hit(rs): rs!=0 and (busy[rs] or (id_valid & (id_memRead|id_longOp) & id_Rd==rs)).
//   With WB_BYPASS=1, a hit is masked when wb_valid & wb_Rd==rs and there is no ID-stage match.
//  stall = Hit(if_Rs1) | Hit(if_Rs2) | (if_longOp & outstanding==MAX_OUTSTANDING).
//  All outputs except outstanding/hazard_error are combinational (zero latency).
//  Flush has priority over stall:
//   ex_branchTaken=1 -> if_flush=1, id_doNOP=1, PCWrite=1, if_write=1 (redirect proceeds).
//   Otherwise stall=1 -> PCWrite=0, if_write=0, id_doNOP=1.
//   Otherwise PCWrite=if_write=1, id_doNOP=if_flush=0.
//  Issue = id_valid & id_longOp & !ex_branchTaken & id_Rd!=0.
//   On issue, busy[id_Rd] sets and outstanding increments at the next edge.
//   id_Rd==0 is not tracked and is not counted.
//  Complete = wb_valid & wb_Rd!=0 & busy[wb_Rd].
//   On complete, busy[wb_Rd] clears and outstanding decrements.
//   wb_valid for a non-busy reg is ignored, with no count change.
//  Issue and complete in the same cycle: outstanding is unchanged. If the registers are equal, busy stays 1 (set wins).
//  Issue while outstanding==MAX_OUTSTANDING (protocol violation): count saturates and hazard_error sets.
//  outstanding never wraps below 0 or above MAX_OUTSTANDING.
//  Watchdog: the stall counter increments on each stalled cycle and clears on any non-stall cycle.
//   When it reaches WATCHDOG_CYCLES, hazard_error sets; the counter saturates.
//   hazard_error clears only on reset.
//  Reset mid-operation drops all pending entries. Later wb_valid for those regs is ignored per the complete rule.
// TESTING
//  1 Load-use: id_valid=1, id_memRead=1, id_Rd=5, if_Rs2=5 -> PCWrite=0, if_write=0, id_doNOP=1 that cycle.
//  2 Long op: issue div to x7, wb 6 cycles later, if_Rs1=7 meanwhile.
//    -> stall for each cycle until wb_valid/wb_Rd=7. With WB_BYPASS=1 no stall in the wb cycle. outstanding 1->0.
//  3 x0 / bypass: id_longOp to x0, then if_Rs1=0 -> no stall, outstanding stays 0.
//    wb_valid for a non-busy x9 -> outstanding unchanged, no error.
//  4 Structural: issue 4 long ops (x1..x4), then if_longOp=1 -> stall until one completes.
//    Same-cycle issue x5 + complete x1 -> outstanding stays 4, busy[1]=0, busy[5]=1.
//  5 Flush priority: stall condition + ex_branchTaken=1 -> if_flush=1, id_doNOP=1, PCWrite=1.
//    An id_longOp in that cycle is not recorded.
//  6 Watchdog/reset: hold busy x3 with if_Rs1=3 for 255 cycles -> hazard_error=1 and stays 1.
//    rst_n=0 mid-stall -> busy, outstanding and hazard_error clear asynchronously; PCWrite=1.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard unit: load-use detection, long-op busy scoreboard,
// outstanding-op limit, branch flush and sticky stall watchdog.
module hazard_scoreboard #(
  parameter int REG_NUM_BITWIDTH = 5,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int WB_BYPASS        = 1,
  parameter int WATCHDOG_CYCLES  = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        id_valid,
  input  logic                        id_memRead,
  input  logic                        id_longOp,
  input  logic [REG_NUM_BITWIDTH-1:0] id_Rd,
  input  logic [REG_NUM_BITWIDTH-1:0] if_Rs1,
  input  logic [REG_NUM_BITWIDTH-1:0] if_Rs2,
  input  logic                        if_longOp,
  input  logic                        wb_valid,
  input  logic [REG_NUM_BITWIDTH-1:0] wb_Rd,
  input  logic                        ex_branchTaken,
  output logic                        PCWrite,
  output logic                        if_write,
  output logic                        id_doNOP,
  output logic                        if_flush,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                        hazard_error
);

  localparam int R  = REG_NUM_BITWIDTH;
  localparam int NR = 2 ** R;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [OW-1:0] MAXO = OW'(MAX_OUTSTANDING);
  localparam logic [WW-1:0] WDC  = WW'(WATCHDOG_CYCLES);

  logic [NR-1:0] busy_q, busy_d;
  logic [OW-1:0] out_q, out_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [R-1:0] src [2];
  logic [1:0]   id_m, byp, hit;
  logic         ld_or_long;
  logic         full, stall, stall_eff;
  logic         iss, cmp;

  assign src[0]     = if_Rs1;
  assign src[1]     = if_Rs2;
  assign ld_or_long = id_valid & (id_memRead | id_longOp);

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      id_m[k] = ld_or_long & (id_Rd == src[k]);
      byp[k]  = (WB_BYPASS != 0) & wb_valid
              & (wb_Rd == src[k]) & !id_m[k];
      hit[k]  = (src[k] != '0)
              & (busy_q[src[k]] | id_m[k]) & !byp[k];
    end
  end

  assign full      = (out_q == MAXO);
  assign stall     = (|hit) | (if_longOp & full);
  assign stall_eff = stall & !ex_branchTaken;

  assign if_flush = ex_branchTaken;
  assign id_doNOP = ex_branchTaken | stall;
  assign PCWrite  = ex_branchTaken | !stall;
  assign if_write = ex_branchTaken | !stall;

  assign iss = id_valid & id_longOp & !ex_branchTaken
             & (id_Rd != '0);
  assign cmp = wb_valid & (wb_Rd != '0) & busy_q[wb_Rd];

  always_comb begin
    busy_d = busy_q;
    out_d  = out_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    // clear before set so a same-register issue wins
    if (cmp) busy_d[wb_Rd] = 1'b0;
    if (iss) busy_d[id_Rd] = 1'b1;
    if (iss && !cmp) begin
      if (full) err_d = 1'b1;
      else      out_d = out_q + OW'(1);
    end else if (cmp && !iss) begin
      if (out_q == '0) err_d = 1'b1;
      else             out_d = out_q - OW'(1);
    end
    if (stall_eff) begin
      if (cnt_q != WDC) cnt_d = cnt_q + WW'(1);
      if (cnt_q >= WDC - WW'(1)) err_d = 1'b1;
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      out_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign outstanding  = out_q;
  assign hazard_error = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: vector table
// for combinational cases plus multi-cycle sequences.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_memRead, id_longOp;
  logic [4:0] id_Rd, if_Rs1, if_Rs2, wb_Rd;
  logic       if_longOp, wb_valid, ex_branchTaken;
  logic       PCWrite, if_write, id_doNOP, if_flush;
  logic [2:0] outstanding;
  logic       hazard_error;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_memRead(id_memRead),
    .id_longOp(id_longOp), .id_Rd(id_Rd),
    .if_Rs1(if_Rs1), .if_Rs2(if_Rs2),
    .if_longOp(if_longOp), .wb_valid(wb_valid),
    .wb_Rd(wb_Rd), .ex_branchTaken(ex_branchTaken),
    .PCWrite(PCWrite), .if_write(if_write),
    .id_doNOP(id_doNOP), .if_flush(if_flush),
    .outstanding(outstanding),
    .hazard_error(hazard_error)
  );

  typedef struct {
    string      name;
    logic       v, mr, lo;
    logic [4:0] rd, rs1, rs2;
    logic       ilo, wv;
    logic [4:0] wrd;
    logic       br;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
  endtask

  task automatic chk_ctl(input string nm, input logic [3:0] exp);
    check(nm, {28'd0, PCWrite, if_write, id_doNOP, if_flush},
          {28'd0, exp});
  endtask

  task automatic idle();
    id_valid = 0; id_memRead = 0; id_longOp = 0; id_Rd = 0;
    if_Rs1 = 0; if_Rs2 = 0; if_longOp = 0;
    wb_valid = 0; wb_Rd = 0; ex_branchTaken = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    #2 rst_n = 0;
    #3 rst_n = 1;
    tick();
  endtask

  task automatic issue(input logic [4:0] rd);
    idle();
    id_valid = 1; id_longOp = 1; id_Rd = rd;
    tick();
    idle();
  endtask

  localparam logic [3:0] RUN   = 4'b1100;
  localparam logic [3:0] STALL = 4'b0010;
  localparam logic [3:0] FLUSH = 4'b1111;

  initial begin
    // name, v, mr, lo, rd, rs1, rs2, ilo, wv, wrd, br, exp
    tbl[0]  = '{"idle",        0,0,0, 0, 0, 0, 0,0, 0,0, RUN};
    tbl[1]  = '{"lu_rs2",      1,1,0, 5, 0, 5, 0,0, 0,0, STALL};
    tbl[2]  = '{"lu_rs1",      1,1,0, 5, 5, 0, 0,0, 0,0, STALL};
    tbl[3]  = '{"lu_x0",       1,1,0, 0, 0, 0, 0,0, 0,0, RUN};
    tbl[4]  = '{"lu_nomatch",  1,1,0, 5, 6, 7, 0,0, 0,0, RUN};
    tbl[5]  = '{"lu_invalid",  0,1,0, 5, 5, 5, 0,0, 0,0, RUN};
    tbl[6]  = '{"lu_wb_same",  1,1,0, 5, 5, 0, 0,1, 5,0, STALL};
    tbl[7]  = '{"lu_branch",   1,1,0, 5, 0, 5, 0,0, 0,1, FLUSH};
    tbl[8]  = '{"branch_only", 0,0,0, 0, 0, 0, 0,0, 0,1, FLUSH};
    tbl[9]  = '{"alu_rd",      1,0,0, 5, 5, 0, 0,0, 0,0, RUN};
    tbl[10] = '{"long_branch", 1,0,1, 4, 4, 0, 0,0, 0,1, FLUSH};

    idle();
    rst_n = 0;
    #2;
    check("rst_out", {29'd0, outstanding}, 0);
    check("rst_err", {31'd0, hazard_error}, 0);
    chk_ctl("rst_ctl", RUN);
    #5 rst_n = 1;
    tick();

    for (int i = 0; i < 11; i++) begin
      id_valid = tbl[i].v; id_memRead = tbl[i].mr;
      id_longOp = tbl[i].lo; id_Rd = tbl[i].rd;
      if_Rs1 = tbl[i].rs1; if_Rs2 = tbl[i].rs2;
      if_longOp = tbl[i].ilo; wb_valid = tbl[i].wv;
      wb_Rd = tbl[i].wrd; ex_branchTaken = tbl[i].br;
      #1 chk_ctl(tbl[i].name, tbl[i].exp);
      tick();
    end
    idle();
    #1 check("flushed_long_not_rec", {29'd0, outstanding}, 0);
    if_Rs1 = 4;
    #1 chk_ctl("flushed_long_no_busy", RUN);

    // long op to x7 with dependent reader
    do_reset();
    id_valid = 1; id_longOp = 1; id_Rd = 7; if_Rs1 = 7;
    #1 chk_ctl("div_issue_stall", STALL);
    tick();
    idle();
    check("div_out1", {29'd0, outstanding}, 1);
    if_Rs1 = 7;
    for (int c = 0; c < 5; c++) begin
      #1 chk_ctl($sformatf("div_wait%0d", c), STALL);
      tick();
    end
    wb_valid = 1; wb_Rd = 7;
    #1 chk_ctl("div_wb_bypass", RUN);
    tick();
    wb_valid = 0;
    #1 check("div_out0", {29'd0, outstanding}, 0);
    chk_ctl("div_after", RUN);

    // x0 and non-busy writeback
    idle();
    id_valid = 1; id_longOp = 1; id_Rd = 0;
    #1 chk_ctl("x0_nostall", RUN);
    tick();
    idle();
    check("x0_out", {29'd0, outstanding}, 0);
    wb_valid = 1; wb_Rd = 9;
    tick();
    idle();
    check("wb9_out", {29'd0, outstanding}, 0);
    check("wb9_err", {31'd0, hazard_error}, 0);

    // structural limit
    for (int r = 1; r <= 4; r++) issue(5'(r));
    check("full_out", {29'd0, outstanding}, 4);
    if_longOp = 1;
    #1 chk_ctl("full_stall", STALL);
    tick();
    wb_valid = 1; wb_Rd = 1;
    #1 chk_ctl("full_stall_wb", STALL);
    tick();
    wb_valid = 0;
    #1 check("after_wb_out", {29'd0, outstanding}, 3);
    chk_ctl("after_wb_run", RUN);
    issue(5'd1);
    check("refill_out", {29'd0, outstanding}, 4);
    id_valid = 1; id_longOp = 1; id_Rd = 5;
    wb_valid = 1; wb_Rd = 1;
    tick();
    idle();
    check("swap_out", {29'd0, outstanding}, 4);
    if_Rs1 = 1;
    #1 chk_ctl("swap_x1_free", RUN);
    if_Rs1 = 5;
    #1 chk_ctl("swap_x5_busy", STALL);

    // busy stall overridden by flush; long op not recorded
    ex_branchTaken = 1;
    id_valid = 1; id_longOp = 1; id_Rd = 8;
    #1 chk_ctl("flush_prio", FLUSH);
    tick();
    idle();
    if_Rs1 = 8;
    #1 chk_ctl("flush_x8_free", RUN);
    check("flush_err", {31'd0, hazard_error}, 0);

    // issue at full
    issue(5'd6);
    check("ovf_out", {29'd0, outstanding}, 4);
    check("ovf_err", {31'd0, hazard_error}, 1);

    // watchdog
    do_reset();
    issue(5'd3);
    if_Rs1 = 3;
    repeat (254) tick();
    check("wd_254", {31'd0, hazard_error}, 0);
    tick();
    check("wd_255", {31'd0, hazard_error}, 1);
    repeat (5) tick();
    check("wd_sticky", {31'd0, hazard_error}, 1);
    check("wd_out", {29'd0, outstanding}, 1);
    #2 rst_n = 0;
    #1;
    check("arst_err", {31'd0, hazard_error}, 0);
    check("arst_out", {29'd0, outstanding}, 0);
    chk_ctl("arst_ctl", RUN);
    #1 rst_n = 1;
    tick();
    idle();
    wb_valid = 1; wb_Rd = 3;
    tick();
    idle();
    check("stale_wb_out", {29'd0, outstanding}, 0);
    check("stale_wb_err", {31'd0, hazard_error}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
